// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. Drives a combinational instruction ROM from the
// program counter and captures {pc, instruction, valid, misalign} into the
// IF/ID register that feeds decode.
//
// Ports
//   clk              : single clock, all state updates on its rising edge
//   rst              : asynchronous, active-low reset
//   stall_i          : hold the PC, the IF/ID register and the fetch counter
//   flush_i          : redirect to flush_pc_i and squash IF/ID (wins over all)
//   flush_pc_i       : redirect address used with flush_i
//   branch_flag_i    : taken branch resolved in ID
//   branch_target_i  : branch destination
//   rom_ce_o         : ROM chip enable (1 = enable)
//   rom_addr_o       : current byte-address PC
//   rom_inst_i       : ROM data, valid in the same cycle as rom_addr_o
//   id_pc_o          : PC of the instruction held for ID
//   id_inst_o        : instruction held for ID
//   id_valid_o       : id_inst_o is a real instruction (0 = bubble)
//   misalign_o       : held instruction came from a misaligned redirect
//   fetch_cnt_o      : number of instructions delivered to ID (wraps)
//   state_o          : FSM state for observation (0 = WAKE, 1 = FETCH)
//
// Control contract: there is no valid/ready handshake toward the ROM. Each
// FETCH cycle consumes rom_inst_i unless stall_i is high; decode sees a new
// IF/ID entry on every edge that is neither stalled nor in WAKE. A stalled
// branch stays asserted by ID until the stall clears, so it is simply
// re-evaluated once stall_i drops.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o,
    output logic              misalign_o,
    output logic [31:0]       fetch_cnt_o,
    output logic              state_o
);

    typedef enum logic {
        WAKE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;

    // Misalignment seen on the last redirect; it is attached to the next
    // instruction actually delivered to ID, then cleared.
    logic                r_mis_pend;
    logic                w_mis_pend_nxt;

    logic [ADDR_W-1:0]   r_id_pc;
    logic [INST_W-1:0]   r_id_inst;
    logic                r_id_valid;
    logic                r_id_mis;
    logic [31:0]         r_cnt;

    logic [ADDR_W-1:0]   w_id_pc_nxt;
    logic [INST_W-1:0]   w_id_inst_nxt;
    logic                w_id_valid_nxt;
    logic                w_id_mis_nxt;
    logic [31:0]         w_cnt_nxt;

    // Redirect targets are forced onto an 8-byte boundary.
    logic [ADDR_W-1:0]   w_flush_aligned;
    logic [ADDR_W-1:0]   w_branch_aligned;

    assign w_flush_aligned  = {flush_pc_i[ADDR_W-1:3], 3'b000};
    assign w_branch_aligned = {branch_target_i[ADDR_W-1:3], 3'b000};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAKE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath selection
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_mis_pend_nxt = r_mis_pend;
        w_id_pc_nxt    = r_id_pc;
        w_id_inst_nxt  = r_id_inst;
        w_id_valid_nxt = r_id_valid;
        w_id_mis_nxt   = r_id_mis;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            WAKE: begin
                w_state_nxt    = FETCH;
                w_pc_nxt       = RESET_PC;
                w_mis_pend_nxt = 1'b0;
                w_id_pc_nxt    = '0;
                w_id_inst_nxt  = '0;
                w_id_valid_nxt = 1'b0;
                w_id_mis_nxt   = 1'b0;
            end

            FETCH: begin
                if (flush_i) begin
                    // Exception redirect overrides stall and branch.
                    w_pc_nxt       = w_flush_aligned;
                    w_mis_pend_nxt = |flush_pc_i[2:0];
                    w_id_pc_nxt    = '0;
                    w_id_inst_nxt  = '0;
                    w_id_valid_nxt = 1'b0;
                    w_id_mis_nxt   = 1'b0;
                end else if (stall_i) begin
                    // Everything holds; defaults already do that.
                end else if (branch_flag_i) begin
                    // No delay slot: the instruction fetched this cycle is dropped.
                    w_pc_nxt       = w_branch_aligned;
                    w_mis_pend_nxt = |branch_target_i[2:0];
                    w_id_pc_nxt    = '0;
                    w_id_inst_nxt  = '0;
                    w_id_valid_nxt = 1'b0;
                    w_id_mis_nxt   = 1'b0;
                end else begin
                    w_pc_nxt       = r_pc + ADDR_W'(8);
                    w_mis_pend_nxt = 1'b0;
                    w_id_pc_nxt    = r_pc;
                    w_id_inst_nxt  = rom_inst_i;
                    w_id_valid_nxt = 1'b1;
                    w_id_mis_nxt   = r_mis_pend;
                    w_cnt_nxt      = r_cnt + 32'd1;
                end
            end

            default: begin
                w_state_nxt = WAKE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // PC, pending misalign flag and IF/ID register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_mis_pend <= 1'b0;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
            r_id_valid <= 1'b0;
            r_id_mis   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_mis_pend <= w_mis_pend_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_id_inst  <= w_id_inst_nxt;
            r_id_valid <= w_id_valid_nxt;
            r_id_mis   <= w_id_mis_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign rom_ce_o    = (r_state == FETCH);
    assign rom_addr_o  = r_pc;
    assign id_pc_o     = r_id_pc;
    assign id_inst_o   = r_id_inst;
    assign id_valid_o  = r_id_valid;
    assign misalign_o  = r_id_mis;
    assign fetch_cnt_o = r_cnt;
    assign state_o     = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A behavioural model tracks what the
// stage should present after each clock edge; directed scenarios are followed
// by a randomized run with occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int ADDR_W = 32;
    localparam int INST_W = 64;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              stall_i = 1'b0;
    logic              flush_i = 1'b0;
    logic [ADDR_W-1:0] flush_pc_i = '0;
    logic              branch_flag_i = 1'b0;
    logic [ADDR_W-1:0] branch_target_i = '0;
    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [INST_W-1:0] rom_inst_i;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic              id_valid_o;
    logic              misalign_o;
    logic [31:0]       fetch_cnt_o;
    logic              state_o;

    fetch_stage #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .RESET_PC ('0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .misalign_o      (misalign_o),
        .fetch_cnt_o     (fetch_cnt_o),
        .state_o         (state_o)
    );

    // ROM: word n (byte address 8n) holds n+1.
    function automatic logic [INST_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return INST_W'(a / 8) + 64'd1;
    endfunction

    assign rom_inst_i = rom_word(rom_addr_o);

    // ---------------- reference model ----------------
    bit                m_fetching;
    logic [ADDR_W-1:0] m_pc;
    bit                m_pend;
    logic [ADDR_W-1:0] m_id_pc;
    logic [INST_W-1:0] m_id_inst;
    bit                m_id_valid;
    bit                m_id_mis;
    logic [31:0]       m_cnt;

    int n_checks = 0;
    int n_err    = 0;

    task automatic model_reset();
        m_fetching = 0;
        m_pc       = '0;
        m_pend     = 0;
        m_id_pc    = '0;
        m_id_inst  = '0;
        m_id_valid = 0;
        m_id_mis   = 0;
        m_cnt      = '0;
    endtask

    task automatic model_bubble();
        m_id_pc    = '0;
        m_id_inst  = '0;
        m_id_valid = 0;
        m_id_mis   = 0;
    endtask

    // One rising edge of the fetch stage, written from the stage's rules.
    task automatic model_edge(input bit st, input bit fl, input logic [31:0] fpc,
                              input bit br, input logic [31:0] tgt);
        if (!m_fetching) begin
            m_fetching = 1;
            model_bubble();
        end else if (fl) begin
            m_pc   = fpc - (fpc % 8);
            m_pend = (fpc % 8) != 0;
            model_bubble();
        end else if (st) begin
            // nothing moves
        end else if (br) begin
            m_pc   = tgt - (tgt % 8);
            m_pend = (tgt % 8) != 0;
            model_bubble();
        end else begin
            m_id_pc    = m_pc;
            m_id_inst  = rom_word(m_pc);
            m_id_valid = 1;
            m_id_mis   = m_pend;
            m_pend     = 0;
            m_cnt      = m_cnt + 1;
            m_pc       = m_pc + 8;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".state"},    64'(state_o),     64'(m_fetching));
        chk({where, ".rom_ce"},   64'(rom_ce_o),    64'(m_fetching));
        chk({where, ".rom_addr"}, 64'(rom_addr_o),  64'(m_pc));
        chk({where, ".id_pc"},    64'(id_pc_o),     64'(m_id_pc));
        chk({where, ".id_inst"},  id_inst_o,        m_id_inst);
        chk({where, ".id_valid"}, 64'(id_valid_o),  64'(m_id_valid));
        chk({where, ".misalign"}, 64'(misalign_o),  64'(m_id_mis));
        chk({where, ".fetch_cnt"},64'(fetch_cnt_o), 64'(m_cnt));
    endtask

    task automatic check_reset_values(input string where);
        chk({where, ".rst_ce"},    64'(rom_ce_o),    64'd0);
        chk({where, ".rst_state"}, 64'(state_o),     64'd0);
        chk({where, ".rst_addr"},  64'(rom_addr_o),  64'd0);
        chk({where, ".rst_id_pc"}, 64'(id_pc_o),     64'd0);
        chk({where, ".rst_inst"},  id_inst_o,        64'd0);
        chk({where, ".rst_valid"}, 64'(id_valid_o),  64'd0);
        chk({where, ".rst_mis"},   64'(misalign_o),  64'd0);
        chk({where, ".rst_cnt"},   64'(fetch_cnt_o), 64'd0);
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: drive inputs, let one rising edge
    // pass, and compare on the next falling edge.
    task automatic step(input string where, input bit st, input bit fl,
                        input logic [31:0] fpc, input bit br, input logic [31:0] tgt);
        stall_i         = st;
        flush_i         = fl;
        flush_pc_i      = fpc;
        branch_flag_i   = br;
        branch_target_i = tgt;
        model_edge(st, fl, fpc, br, tgt);
        @(negedge clk);
        check_all(where);
    endtask

    task automatic run(input string where);
        step(where, 0, 0, 32'h0, 0, 32'h0);
    endtask

    // Asynchronous reset pulse started between edges; released on a falling edge.
    task automatic async_reset(input string where);
        #2 rst = 1'b0;
        stall_i = 0; flush_i = 0; branch_flag_i = 0;
        #1;
        model_reset();
        check_reset_values(where);
        @(negedge clk);
        check_all(where);
        rst = 1'b1;
    endtask

    // ---------------- sequence ----------------
    initial begin
        model_reset();
        #3;
        check_reset_values("por");
        @(negedge clk);
        check_all("por_hold");
        rst = 1'b1;

        // Start-up and first fetches.
        step("boot_e1", 0, 0, 0, 0, 0);
        chk("boot_e1.ce_const", 64'(rom_ce_o), 64'd1);
        chk("boot_e1.addr_const", 64'(rom_addr_o), 64'h0);
        run("boot_e2");
        chk("boot_e2.inst_const", id_inst_o, 64'd1);
        chk("boot_e2.addr_const", 64'(rom_addr_o), 64'h8);
        run("boot_e3");
        chk("boot_e3.inst_const", id_inst_o, 64'd2);
        chk("boot_e3.cnt_const", 64'(fetch_cnt_o), 64'd2);
        run("boot_e4");
        chk("boot_e4.addr_const", 64'(rom_addr_o), 64'h18);

        // Three stalled edges at 0x18, then resume.
        for (int i = 0; i < 3; i++) begin
            step("stall", 1, 0, 0, 0, 0);
            chk("stall.addr_const", 64'(rom_addr_o), 64'h18);
            chk("stall.cnt_const", 64'(fetch_cnt_o), 64'd3);
        end
        run("resume1");
        chk("resume1.id_pc_const", 64'(id_pc_o), 64'h18);
        run("resume2");
        chk("resume2.id_pc_const", 64'(id_pc_o), 64'h20);

        // Taken branch from 0x10 to 0x40.
        step("to10", 0, 1, 32'h10, 0, 0);
        step("br40", 0, 0, 0, 1, 32'h40);
        chk("br40.valid_const", 64'(id_valid_o), 64'd0);
        chk("br40.addr_const", 64'(rom_addr_o), 64'h40);
        run("br40_next");
        chk("br40_next.id_pc_const", 64'(id_pc_o), 64'h40);

        // Stall with branch holds the PC; branch taken once stall drops.
        step("stbr", 1, 0, 0, 1, 32'h80);
        step("stbr_go", 0, 0, 0, 1, 32'h80);

        // Misaligned branch target.
        step("br43", 0, 0, 0, 1, 32'h43);
        chk("br43.addr_const", 64'(rom_addr_o), 64'h40);
        run("br43_n1");
        chk("br43_n1.mis_const", 64'(misalign_o), 64'd1);
        run("br43_n2");
        chk("br43_n2.mis_const", 64'(misalign_o), 64'd0);

        // Flush overrides stall and branch.
        step("flush", 1, 1, 32'h100, 1, 32'h200);
        chk("flush.addr_const", 64'(rom_addr_o), 64'h100);
        run("flush_n1");

        // PC wraparound.
        step("to_top", 0, 1, 32'hFFFF_FFF8, 0, 0);
        run("wrap");
        chk("wrap.addr_const", 64'(rom_addr_o), 64'h0);
        chk("wrap.mis_const", 64'(misalign_o), 64'd0);

        // Reset while stalled at 0x28, then restart.
        step("to28", 0, 1, 32'h28, 0, 0);
        step("st28", 1, 0, 0, 0, 0);
        stall_i = 1;
        async_reset("rst_mid");
        step("re_e1", 0, 0, 0, 0, 0);
        run("re_e2");
        chk("re_e2.inst_const", id_inst_o, 64'd1);
        run("re_e3");
        chk("re_e3.cnt_const", 64'(fetch_cnt_o), 64'd2);

        // Randomized run.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd",
                     $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 6,
                     $urandom,
                     $urandom_range(0, 99) < 15,
                     $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
